// File: rtl/stdp_synapse_if.sv
// Spike inputs and weight/update status outputs of the STDP synapse.
interface stdp_synapse_if #(
    parameter int WEIGHT_W = 8,
    parameter int WIN_W    = 4
);
    logic                pre_spike;
    logic                post_spike;
    logic                learn_en;
    logic [WEIGHT_W-1:0] weight;
    logic                update_w_flag;
    logic                ltp;
    logic [WIN_W-1:0]    time_diff;

    modport master (
        output pre_spike, post_spike, learn_en,
        input  weight, update_w_flag, ltp, time_diff
    );

    modport slave (
        input  pre_spike, post_spike, learn_en,
        output weight, update_w_flag, ltp, time_diff
    );
endinterface

// File: rtl/stdp_synapse.sv
// STDP synapse: spike-age counters, pairing qualifier and an IDLE/APPLY weight update stage.
// Define STDP_NEAREST_ONLY_EN for nearest-neighbour pairing (each spike pairs at most once).
module stdp_synapse #(
    parameter int WEIGHT_W  = 8,
    parameter int WIN_W     = 4,
    parameter int A_PLUS    = 8,
    parameter int A_MINUS   = 4,
    parameter int TAU_SHIFT = 1,
    parameter int W_INIT    = 128
) (
    input logic           clk,
    input logic           rst,
    stdp_synapse_if.slave syn
);
    localparam logic [WIN_W-1:0]  WIN_MAX = '1;
    localparam logic [WEIGHT_W:0] W_MAX   = {1'b0, {WEIGHT_W{1'b1}}};

    typedef enum logic {IDLE, APPLY} state_t;
    state_t state_q, state_d;

    // Index 0 tracks the presynaptic neuron, index 1 the postsynaptic one.
    logic [1:0]       spk;
    logic [1:0]       in_win;
    logic [1:0]       clr;
    logic [WIN_W-1:0] cnt_q [2];
    logic [WIN_W-1:0] cnt_d [2];
    logic             ltp_evt, ltd_evt, evt;

    logic                evt_ltp_q, evt_ltp_d;
    logic [WIN_W-1:0]    evt_dt_q, evt_dt_d;
    logic [WEIGHT_W-1:0] weight_q, weight_d;
    logic                flag_q, flag_d;
    logic                ltp_q, ltp_d;
    logic [WIN_W-1:0]    tdiff_q, tdiff_d;

    logic [WIN_W-1:0]    shamt;
    logic [WEIGHT_W:0]   a_sel, mag, w_up, w_dn;

    assign spk = {syn.post_spike, syn.pre_spike};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_win
            assign in_win[gi] = (cnt_q[gi] != '0) && (cnt_q[gi] != WIN_MAX);
        end
    endgenerate

    assign ltp_evt = syn.learn_en && (spk == 2'b10) && in_win[0];
    assign ltd_evt = syn.learn_en && (spk == 2'b01) && in_win[1];
    assign evt     = ltp_evt || ltd_evt;

`ifdef STDP_NEAREST_ONLY_EN
    assign clr = {ltd_evt, ltp_evt};
`else
    assign clr = 2'b00;
`endif

    // A fresh spike wins over a clear; an idle or saturated counter holds.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = cnt_q[i];
            if (spk[i])         cnt_d[i] = WIN_W'(1);
            else if (clr[i])    cnt_d[i] = '0;
            else if (in_win[i]) cnt_d[i] = cnt_q[i] + WIN_W'(1);
        end
    end

    assign shamt = (evt_dt_q - WIN_W'(1)) >> TAU_SHIFT;
    assign a_sel = evt_ltp_q ? (WEIGHT_W+1)'(A_PLUS) : (WEIGHT_W+1)'(A_MINUS);
    assign mag   = a_sel >> shamt;
    assign w_up  = {1'b0, weight_q} + mag;
    assign w_dn  = {1'b0, weight_q} - mag;

    always_comb begin
        state_d   = evt ? APPLY : IDLE;
        evt_ltp_d = evt_ltp_q;
        evt_dt_d  = evt_dt_q;
        weight_d  = weight_q;
        flag_d    = 1'b0;
        ltp_d     = ltp_q;
        tdiff_d   = tdiff_q;
        if (evt) begin
            evt_ltp_d = ltp_evt;
            evt_dt_d  = ltp_evt ? cnt_q[0] : cnt_q[1];
        end
        case (state_q)
            APPLY: begin
                flag_d  = 1'b1;
                ltp_d   = evt_ltp_q;
                tdiff_d = evt_dt_q;
                if (evt_ltp_q)
                    weight_d = (w_up > W_MAX) ? W_MAX[WEIGHT_W-1:0] : w_up[WEIGHT_W-1:0];
                else
                    weight_d = w_dn[WEIGHT_W] ? '0 : w_dn[WEIGHT_W-1:0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
            evt_ltp_q <= 1'b0;
            evt_dt_q  <= '0;
            weight_q  <= WEIGHT_W'(W_INIT);
            flag_q    <= 1'b0;
            ltp_q     <= 1'b0;
            tdiff_q   <= '0;
        end else begin
            state_q   <= state_d;
            for (int i = 0; i < 2; i++) cnt_q[i] <= cnt_d[i];
            evt_ltp_q <= evt_ltp_d;
            evt_dt_q  <= evt_dt_d;
            weight_q  <= weight_d;
            flag_q    <= flag_d;
            ltp_q     <= ltp_d;
            tdiff_q   <= tdiff_d;
        end
    end

    assign syn.weight        = weight_q;
    assign syn.update_w_flag = flag_q;
    assign syn.ltp           = ltp_q;
    assign syn.time_diff     = tdiff_q;
endmodule

// File: tb/tb_stdp_synapse.sv
// Directed bench for stdp_synapse; applied updates are checked against a scoreboard queue.
module tb_stdp_synapse;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass = 0;
    int   n_total = 0;
    int   model_w = 128;

    typedef struct {
        bit l;
        int dt;
        int w;
    } exp_t;
    exp_t sb[$];

    stdp_synapse_if syn ();

    stdp_synapse dut (
        .clk (clk),
        .rst (rst),
        .syn (syn)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total = n_total + 1;
        assert (obs === exp_v) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    endtask

    // Spec-level expectation for one applied pairing.
    task automatic push_exp(input bit l, input int dt);
        int a, mag;
        a   = l ? 8 : 4;
        mag = a >> ((dt - 1) >> 1);
        if (l) model_w = (model_w + mag > 255) ? 255 : model_w + mag;
        else   model_w = (model_w - mag < 0)   ? 0   : model_w - mag;
        sb.push_back('{l, dt, model_w});
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic p, input logic q);
        syn.pre_spike  = p;
        syn.post_spike = q;
        @(negedge clk);
        syn.pre_spike  = 1'b0;
        syn.post_spike = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        model_w = 128;
    endtask

    always @(negedge clk) begin
        if (syn.update_w_flag === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_flag", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("update: ltp=%0d dt=%0d weight=%0d (expect ltp=%0d dt=%0d weight=%0d)",
                         syn.ltp, syn.time_diff, syn.weight, e.l, e.dt, e.w);
                chk("sb_ltp", 32'(syn.ltp), 32'(e.l));
                chk("sb_dt", 32'(syn.time_diff), 32'(e.dt));
                chk("sb_weight", 32'(syn.weight), 32'(e.w));
            end
        end
    end

    initial begin
        syn.pre_spike  = 1'b0;
        syn.post_spike = 1'b0;
        syn.learn_en   = 1'b1;
        idle(2);
        chk("rst_weight", 32'(syn.weight), 32'd128);
        chk("rst_flag", 32'(syn.update_w_flag), 32'd0);
        chk("rst_ltp", 32'(syn.ltp), 32'd0);
        chk("rst_tdiff", 32'(syn.time_diff), 32'd0);
        rst = 1'b0;

        // pre cycle 0, post cycle 3: LTP dt=3, flag at the second edge after the post spike
        pulse(1'b1, 1'b0);
        idle(2);
        push_exp(1'b1, 3);
        pulse(1'b0, 1'b1);
        chk("ltp_lat_flag_early", 32'(syn.update_w_flag), 32'd0);
        idle(1);
        chk("ltp_flag", 32'(syn.update_w_flag), 32'd1);
        chk("ltp_weight", 32'(syn.weight), 32'd132);
        chk("ltp_pol", 32'(syn.ltp), 32'd1);
        chk("ltp_dt", 32'(syn.time_diff), 32'd3);
        idle(1);
        chk("ltp_flag_one_cycle", 32'(syn.update_w_flag), 32'd0);
        chk("ltp_hold_dt", 32'(syn.time_diff), 32'd3);

        // post cycle 0, pre cycle 1: LTD dt=1
        do_reset();
        pulse(1'b0, 1'b1);
        push_exp(1'b0, 1);
        pulse(1'b1, 1'b0);
        idle(2);
        chk("ltd_weight", 32'(syn.weight), 32'd124);
        chk("ltd_pol", 32'(syn.ltp), 32'd0);
        chk("ltd_dt", 32'(syn.time_diff), 32'd1);

        // pre cycle 0, post cycle 15: out of window
        do_reset();
        pulse(1'b1, 1'b0);
        idle(14);
        pulse(1'b0, 1'b1);
        idle(3);
        chk("win_weight", 32'(syn.weight), 32'd128);

        // coincident spikes, then post cycle 2: LTP dt=2
        do_reset();
        pulse(1'b1, 1'b1);
        idle(1);
        push_exp(1'b1, 2);
        pulse(1'b0, 1'b1);
        idle(2);
        chk("coinc_weight", 32'(syn.weight), 32'd136);
        chk("coinc_dt", 32'(syn.time_diff), 32'd2);

        // learning disabled: no update
        do_reset();
        syn.learn_en = 1'b0;
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        idle(3);
        chk("nolearn_weight", 32'(syn.weight), 32'd128);
        syn.learn_en = 1'b1;

        // saturation at the top, then floor at zero
        do_reset();
        repeat (15) begin
            pulse(1'b1, 1'b0);
            push_exp(1'b1, 1);
            pulse(1'b0, 1'b1);
            idle(20);
        end
        pulse(1'b1, 1'b0);
        idle(4);
        push_exp(1'b1, 5);
        pulse(1'b0, 1'b1);
        idle(20);
        chk("sat_pre_250", 32'(syn.weight), 32'd250);
        repeat (2) begin
            pulse(1'b1, 1'b0);
            push_exp(1'b1, 1);
            pulse(1'b0, 1'b1);
            idle(20);
            chk("sat_255", 32'(syn.weight), 32'd255);
        end
        repeat (65) begin
            pulse(1'b0, 1'b1);
            push_exp(1'b0, 1);
            pulse(1'b1, 1'b0);
            idle(20);
        end
        chk("floor_0", 32'(syn.weight), 32'd0);

        // pre cycle 0, posts cycles 2 and 3: back-to-back events in the default mode
        do_reset();
        pulse(1'b1, 1'b0);
        idle(1);
        push_exp(1'b1, 2);
        pulse(1'b0, 1'b1);
`ifndef STDP_NEAREST_ONLY_EN
        push_exp(1'b1, 3);
`endif
        pulse(1'b0, 1'b1);
        idle(3);
`ifdef STDP_NEAREST_ONLY_EN
        chk("b2b_weight", 32'(syn.weight), 32'd136);
`else
        chk("b2b_weight", 32'(syn.weight), 32'd140);
`endif

        // pre cycle 0, posts cycles 2 and 4
        do_reset();
        pulse(1'b1, 1'b0);
        idle(1);
        push_exp(1'b1, 2);
        pulse(1'b0, 1'b1);
        idle(1);
`ifndef STDP_NEAREST_ONLY_EN
        push_exp(1'b1, 4);
`endif
        pulse(1'b0, 1'b1);
        idle(3);
`ifdef STDP_NEAREST_ONLY_EN
        chk("pair_weight", 32'(syn.weight), 32'd136);
`else
        chk("pair_weight", 32'(syn.weight), 32'd140);
`endif

        // same pattern with rst in cycle 3 (plus an ignored pre spike): pending event dropped
        do_reset();
        pulse(1'b1, 1'b0);
        idle(1);
        pulse(1'b0, 1'b1);
        rst = 1'b1;
        syn.pre_spike = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        syn.pre_spike = 1'b0;
        model_w = 128;
        chk("rst_drop_flag", 32'(syn.update_w_flag), 32'd0);
        pulse(1'b0, 1'b1);
        idle(3);
        chk("rst_drop_weight", 32'(syn.weight), 32'd128);
        chk("rst_drop_dt", 32'(syn.time_diff), 32'd0);

        idle(2);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
